// File: rtl/core_mem_if.sv
// Per-core memory port adapter: turns a one-cycle core request into a held
// controller strobe, waits for the grant, and returns read data or a timeout error.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a core request, no strobe to the controller
// WAIT_ACQ  | strobe, address and write data held until mc_acq or timeout
// WAIT_DATA | grant taken for a read; capture mc_dq on the next edge
module core_mem_if #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          core_rd,
    input  logic          core_wr,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ready,
    output logic          core_done,
    output logic [DW-1:0] core_rdata,
    output logic          core_err,
    output logic          mc_rden,
    output logic          mc_wren,
    output logic [AW-1:0] mc_addr,
    output logic [DW-1:0] mc_din,
    input  logic          mc_acq,
    input  logic [DW-1:0] mc_dq,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WAIT_ACQ, WAIT_DATA} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT) - 16'd1;

    state_t        state, state_nx;
    logic [15:0]   cnt, cnt_nx;
    logic          rden_nx, wren_nx, done_nx, err_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] din_nx, rdata_nx;

    assign core_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mc_rden    <= 1'b0;
            mc_wren    <= 1'b0;
            mc_addr    <= '0;
            mc_din     <= '0;
            core_rdata <= '0;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            mc_rden    <= rden_nx;
            mc_wren    <= wren_nx;
            mc_addr    <= addr_nx;
            mc_din     <= din_nx;
            core_rdata <= rdata_nx;
            core_done  <= done_nx;
            core_err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rden_nx  = mc_rden;
        wren_nx  = mc_wren;
        addr_nx  = mc_addr;
        din_nx   = mc_din;
        rdata_nx = core_rdata;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (core_rd && core_wr) begin
                    err_nx = 1'b1;
                end else if (core_rd || core_wr) begin
                    addr_nx  = core_addr;
                    din_nx   = core_wdata;
                    rden_nx  = core_rd;
                    wren_nx  = core_wr;
                    state_nx = WAIT_ACQ;
                end
            end
            WAIT_ACQ: begin
                // A grant on the terminal-count edge still wins over the timeout.
                if (mc_acq) begin
                    rden_nx = 1'b0;
                    wren_nx = 1'b0;
                    if (mc_wren) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_DATA;
                    end
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    rden_nx  = 1'b0;
                    wren_nx  = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            WAIT_DATA: begin
                rdata_nx = mc_dq;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_mem_if.sv
// Directed bench for core_mem_if: reads, writes, timeout, illegal request,
// back-to-back reads and asynchronous reset, with hand-computed expectations.
module tb_core_mem_if;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       core_rd = 1'b0, core_wr = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0;
    logic       core_ready, core_done, core_err;
    logic [7:0] core_rdata;
    logic       mc_rden, mc_wren;
    logic [7:0] mc_addr, mc_din;
    logic       mc_acq = 1'b0;
    logic [7:0] mc_dq = '0;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    core_mem_if #(.AW(8), .DW(8), .TIMEOUT(8)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .core_rd(core_rd), .core_wr(core_wr),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done),
        .core_rdata(core_rdata), .core_err(core_err),
        .mc_rden(mc_rden), .mc_wren(mc_wren),
        .mc_addr(mc_addr), .mc_din(mc_din),
        .mc_acq(mc_acq), .mc_dq(mc_dq), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_rd = rd; core_wr = wr; core_addr = a; core_wdata = d;
        tick();
        core_rd = 1'b0; core_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_ready", core_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rden", mc_rden, 0);
        chk("rst_rdata", core_rdata, 0);
        rst_n = 1'b1;
        tick();

        // read, immediate grant
        issue(1, 0, 8'h10, 8'h00);
        chk("rd_rden_on", mc_rden, 1);
        chk("rd_addr", mc_addr, 8'h10);
        chk("rd_busy", busy, 1);
        chk("rd_ready", core_ready, 0);
        mc_acq = 1'b1;
        tick();
        mc_acq = 1'b0; mc_dq = 8'hA5;
        chk("rd_rden_off", mc_rden, 0);
        chk("rd_done_early", core_done, 0);
        tick();
        chk("rd_done", core_done, 1);
        chk("rd_data", core_rdata, 8'hA5);
        chk("rd_busy_after", busy, 0);
        mc_dq = 8'h00;
        tick();
        chk("rd_done_pulse", core_done, 0);
        chk("rd_data_hold", core_rdata, 8'hA5);

        // write, grant after 4 idle cycles
        issue(0, 1, 8'h3F, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            chk("wr_wren", mc_wren, 1);
            chk("wr_addr", mc_addr, 8'h3F);
            chk("wr_din", mc_din, 8'h5A);
            chk("wr_done_early", core_done, 0);
            if (i == 4) mc_acq = 1'b1;
            tick();
        end
        mc_acq = 1'b0;
        chk("wr_wren_off", mc_wren, 0);
        chk("wr_done", core_done, 1);
        chk("wr_rdata_kept", core_rdata, 8'hA5);
        tick();
        chk("wr_done_pulse", core_done, 0);

        // timeout after 8 waiting edges
        issue(1, 0, 8'h20, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("to_rden", mc_rden, 1);
            chk("to_err_early", core_err, 0);
            tick();
        end
        chk("to_err", core_err, 1);
        chk("to_rden_off", mc_rden, 0);
        chk("to_ready", core_ready, 1);
        chk("to_no_done", core_done, 0);
        chk("to_rdata_kept", core_rdata, 8'hA5);
        tick();
        chk("to_err_pulse", core_err, 0);

        // grant on the terminal-count edge wins
        issue(1, 0, 8'h30, 8'h00);
        for (int i = 0; i < 7; i++) tick();
        mc_acq = 1'b1;
        tick();
        mc_acq = 1'b0; mc_dq = 8'hC3;
        chk("tc_no_err", core_err, 0);
        chk("tc_busy", busy, 1);
        tick();
        chk("tc_done", core_done, 1);
        chk("tc_data", core_rdata, 8'hC3);

        // illegal request
        issue(1, 1, 8'h44, 8'h55);
        chk("ill_err", core_err, 1);
        chk("ill_rden", mc_rden, 0);
        chk("ill_wren", mc_wren, 0);
        chk("ill_ready", core_ready, 1);
        chk("ill_no_done", core_done, 0);
        tick();
        chk("ill_err_pulse", core_err, 0);

        // back-to-back reads
        issue(1, 0, 8'h40, 8'h00);
        mc_acq = 1'b1; tick();
        mc_acq = 1'b0; mc_dq = 8'h11; tick();
        chk("bb1_done", core_done, 1);
        chk("bb1_data", core_rdata, 8'h11);
        chk("bb1_ready", core_ready, 1);
        issue(1, 0, 8'h41, 8'h00);
        chk("bb2_rden", mc_rden, 1);
        chk("bb2_addr", mc_addr, 8'h41);
        chk("bb2_done_clr", core_done, 0);
        mc_acq = 1'b1; tick();
        mc_acq = 1'b0; mc_dq = 8'h22; tick();
        chk("bb2_done", core_done, 1);
        chk("bb2_data", core_rdata, 8'h22);
        tick();

        // async reset during WAIT_DATA
        issue(1, 0, 8'h50, 8'h00);
        mc_acq = 1'b1; tick();
        mc_acq = 1'b0; mc_dq = 8'h77;
        chk("ar_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", core_ready, 1);
        chk("ar_busy", busy, 0);
        chk("ar_rden", mc_rden, 0);
        chk("ar_addr", mc_addr, 0);
        chk("ar_rdata", core_rdata, 0);
        chk("ar_done", core_done, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_no_done", core_done, 0);
            chk("ar_rdata_zero", core_rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
